regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//   Shares the single register-file write port (wa/wd/regwrite) between two writeback requesters,
//   e.g. ALU result and memory-load return, using valid/ready handshakes and round-robin priority.
//   Accepted writes are staged one cycle, then driven to the register file.
//   Staged data is exposed on a bypass port for forwarding.
//   Sits between the writeback sources and register_file; it is the only driver of the write port.
// PARAMETERS
//   DATA_W        32  write data width
//   ADDR_W        5   register address width (32 registers)
//   ZERO_DISCARD  1   1: writes to address 0 are accepted and dropped (MIPS $zero); 0: passed through
//   CNT_W         16  width of the saturating write counter
// PORTS
//   clk        in   1       rising-edge clock
//   rst_n      in   1       synchronous active-low reset
//   stall      in   1       1: accept nothing this cycle
//   req0_valid in   1       requester 0 has a write
//   req0_addr  in   ADDR_W  requester 0 destination register
//   req0_data  in   DATA_W  requester 0 write data
//   req0_ready out  1       requester 0 write accepted this cycle (combinational)
//   req1_valid in   1       requester 1 has a write
//   req1_addr  in   ADDR_W  requester 1 destination register
//   req1_data  in   DATA_W  requester 1 write data
//   req1_ready out  1       requester 1 write accepted this cycle (combinational)
//   wa         out  ADDR_W  register file write address (registered)
//   wd         out  DATA_W  register file write data (registered)
//   regwrite   out  1       register file write enable (registered)
//   chk_addr   in   ADDR_W  bypass lookup address
//   chk_hit    out  1       staged write targets chk_addr (combinational)
//   chk_data   out  DATA_W  staged write data (= wd)
//   wr_count   out  CNT_W   number of regwrite pulses issued; saturates at all-ones
// BEHAVIOUR
//   Reset (rst_n=0 at posedge):
//   - regwrite=0, wa=0, wd=0, wr_count=0, prio=0.
//   - reqX_ready forced 0 combinationally while rst_n=0.
//   Grant (combinational, one requester max):
//   - stall=1: no grant.
//   - Only one valid: grant it.
//   - Both valid: grant requester indicated by prio.
//   - reqX_ready = rst_n & ~stall & granted X. Transfer = valid & ready in the same cycle.
//   - A requester holds valid/addr/data stable until ready; its valid must not depend on ready.
//   Round-robin:
//   - After any transfer from requester i, prio <= ~i.
//   - No transfer: prio unchanged.
//   - Continuous contention therefore alternates 0,1,0,1.
//   Staging (the single pipeline stage; the register file never back-pressures):
//   - At each posedge, regwrite <= transfer & ~(ZERO_DISCARD & addr==0).
//   - wa/wd load the granted addr/data on transfer; they hold their value otherwise.
//   - Latency: transfer accepted at edge N -> regwrite=1 during cycle N+1 -> register updated at edge N+1.
//   - Back-to-back transfers give one regwrite per cycle, no bubbles.
//   Address 0 with ZERO_DISCARD=1: ready still asserted and prio still rotates; no regwrite, wr_count unchanged.
//   Both requesters on the same address: only the granted one proceeds; the other waits; order follows grant order.
//   Bypass: chk_hit = regwrite & (wa==chk_addr) & ~(ZERO_DISCARD & chk_addr==0); chk_data = wd regardless of hit.
//   wr_count: +1 on every cycle with regwrite=1; holds at 2^CNT_W-1.
//   Reset mid-operation:
//   - A staged write is cancelled: regwrite=0 on the next cycle.
//   - Requesters see ready=0 and must re-present their writes after reset.
// TESTING
//   1. rst_n=0 for 3 cycles, both valid -> ready0=ready1=0 throughout; then regwrite=0, wr_count=0.
//   2. req0 addr=5 data=0xDEADBEEF, cycle after reset -> ready0=1 that cycle; next cycle regwrite=1, wa=5, wd=0xDEADBEEF, wr_count=1.
//   3. Both valid for 6 cycles (req0 addr=1, req1 addr=2, data=cycle index) -> grants 0,1,0,1,0,1; wa sequence 1,2,1,2,1,2, one cycle late.
//   4. req1 addr=0 data=0x1234 -> ready1=1; regwrite stays 0; wr_count unchanged; next contended grant goes to req0.
//   5. stall=1 for 2 cycles with req0 valid -> ready0=0, regwrite=0; stall=0 -> accepted, then regwrite=1.
//   6. Accept addr=7 data=0xA5A5A5A5, drive chk_addr=7 next cycle -> chk_hit=1, chk_data=0xA5A5A5A5.
//      Assert rst_n=0 in that same cycle -> regwrite=0 after the edge.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin arbiter for the register-file write port.
// Accepted writes are staged one cycle before driving wa/wd/regwrite; the staged entry doubles as a bypass source.
module regfile_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter bit ZERO_DISCARD = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [ADDR_W-1:0] wa,
    output logic [DATA_W-1:0] wd,
    output logic              regwrite,
    input  logic [ADDR_W-1:0] chk_addr,
    output logic              chk_hit,
    output logic [DATA_W-1:0] chk_data,
    output logic [CNT_W-1:0]  wr_count
);

    logic              prio;
    logic              grant0;
    logic              grant1;
    logic              xfer0;
    logic              xfer1;
    logic              xfer;
    logic              drop;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // prio names the requester that wins when both are valid
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && !stall) begin
            if (req0_valid && req1_valid) begin
                grant0 = ~prio;
                grant1 = prio;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer0      = req0_valid & req0_ready;
    assign xfer1      = req1_valid & req1_ready;
    assign xfer       = xfer0 | xfer1;
    assign sel_addr   = xfer1 ? req1_addr : req0_addr;
    assign sel_data   = xfer1 ? req1_data : req0_data;
    assign drop       = ZERO_DISCARD && (sel_addr == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regwrite <= 1'b0;
            wa       <= '0;
            wd       <= '0;
            wr_count <= '0;
            prio     <= 1'b0;
        end else begin
            regwrite <= xfer & ~drop;
            if (xfer) begin
                wa   <= sel_addr;
                wd   <= sel_data;
                prio <= xfer0;
            end
            // counts the pulse being launched, so it already reads 1 during the first regwrite
            if (xfer && !drop && (wr_count != '1)) begin
                wr_count <= wr_count + 1'b1;
            end
        end
    end

    assign chk_hit  = regwrite && (wa == chk_addr) && !(ZERO_DISCARD && (chk_addr == '0));
    assign chk_data = wd;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of grant, staging and counting.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        regwrite;
    logic [4:0]  chk_addr;
    logic        chk_hit;
    logic [31:0] chk_data;
    logic [7:0]  wr_count;

    int checks = 0;
    int errors = 0;

    // model state
    logic        m_prio;
    logic        m_rw;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic [7:0]  m_cnt;

    regfile_write_arbiter #(
        .DATA_W(32), .ADDR_W(5), .ZERO_DISCARD(1'b1), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .wa(wa), .wd(wd), .regwrite(regwrite),
        .chk_addr(chk_addr), .chk_hit(chk_hit), .chk_data(chk_data), .wr_count(wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic exp_rdy(input int i);
        if (!rst_n || stall) return 1'b0;
        if (req0_valid && req1_valid) return (m_prio == i[0]);
        return (i == 0) ? req0_valid : req1_valid;
    endfunction

    // advance the model by one clock edge using the currently driven inputs, then step past the edge
    task automatic tick();
        logic        r0, r1, t;
        logic [4:0]  a;
        logic [31:0] d;
        r0 = exp_rdy(0);
        r1 = exp_rdy(1);
        t = 1'b0; a = '0; d = '0;
        if (!rst_n) begin
            m_prio = 1'b0; m_rw = 1'b0; m_wa = '0; m_wd = '0; m_cnt = '0;
        end else begin
            if (r0 && req0_valid) begin
                t = 1'b1; a = req0_addr; d = req0_data; m_prio = 1'b1;
            end else if (r1 && req1_valid) begin
                t = 1'b1; a = req1_addr; d = req1_data; m_prio = 1'b0;
            end
            m_rw = t && (a != 0);
            if (t) begin
                m_wa = a;
                m_wd = d;
            end
            if (m_rw && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h22;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0 cyc %0d got %b exp 0", i, req0_ready); end
            checks++;
            if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1 cyc %0d got %b exp 0", i, req1_ready); end
            tick();
        end
        rst_n = 1'b1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (regwrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b exp 0", regwrite); end
        checks++;
        if (wr_count !== 8'd0) begin errors++; $display("FAIL reset_wr_count got %0d exp 0", wr_count); end
        checks++;
        if (wa !== 5'd0 || wd !== 32'd0) begin errors++; $display("FAIL reset_wa_wd got %0d/%h exp 0/0", wa, wd); end
        tick();
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready0 got %b exp 1", req0_ready); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (regwrite !== 1'b1 || wa !== 5'd5 || wd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_write got rw=%b wa=%0d wd=%h exp rw=1 wa=5 wd=deadbeef", regwrite, wa, wd);
        end
        checks++;
        if (wr_count !== 8'd1) begin errors++; $display("FAIL single_count got %0d exp 1", wr_count); end
        tick();
        @(negedge clk);
        checks++;
        if (regwrite !== 1'b0) begin errors++; $display("FAIL single_pulse_end got %b exp 0", regwrite); end
        tick();
    endtask

    task automatic test_contention();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req0_valid = 1'b1; req0_addr = 5'd1; req0_data = i;
            req1_valid = 1'b1; req1_addr = 5'd2; req1_data = i;
            @(negedge clk);
            checks++;
            if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                errors++; $display("FAIL contend_grant cyc %0d got %b%b exp grant %0d", i, req1_ready, req0_ready, i % 2);
            end
            if (i > 0) begin
                checks++;
                if (regwrite !== 1'b1 || wa !== ((i % 2 == 1) ? 5'd1 : 5'd2) || wd !== 32'(i - 1)) begin
                    errors++; $display("FAIL contend_stage cyc %0d got rw=%b wa=%0d wd=%0d", i, regwrite, wa, wd);
                end
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (regwrite !== 1'b1 || wa !== 5'd2 || wd !== 32'd5 || wr_count !== 8'd6) begin
            errors++; $display("FAIL contend_last got rw=%b wa=%0d wd=%0d cnt=%0d exp 1/2/5/6", regwrite, wa, wd, wr_count);
        end
        tick();
    endtask

    task automatic test_zero_discard();
        logic [7:0] c_before;
        req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h44;
        tick();
        idle_inputs();
        c_before = m_cnt;
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1) begin errors++; $display("FAIL zero_ready1 got %b exp 1", req1_ready); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (regwrite !== 1'b0) begin errors++; $display("FAIL zero_regwrite got %b exp 0", regwrite); end
        checks++;
        if (wr_count !== c_before) begin errors++; $display("FAIL zero_count got %0d exp %0d", wr_count, c_before); end
        checks++;
        if (chk_hit !== 1'b0) begin errors++; $display("FAIL zero_chk_hit got %b exp 0", chk_hit); end
        req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'h66;
        req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h77;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL zero_prio got r0=%b r1=%b exp r0=1 r1=0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1 || wd !== 32'h66) begin
            errors++; $display("FAIL same_addr_order got r1=%b wd=%h exp r1=1 wd=66", req1_ready, wd);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (regwrite !== 1'b1 || wd !== 32'h77) begin errors++; $display("FAIL same_addr_second got rw=%b wd=%h exp 1/77", regwrite, wd); end
        tick();
    endtask

    task automatic test_stall();
        stall = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = $urandom;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (req0_ready !== 1'b0) begin errors++; $display("FAIL stall_ready0 cyc %0d got %b exp 0", i, req0_ready); end
            tick();
            @(negedge clk);
            checks++;
            if (regwrite !== 1'b0) begin errors++; $display("FAIL stall_regwrite cyc %0d got %b exp 0", i, regwrite); end
        end
        stall = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL unstall_ready0 got %b exp 1", req0_ready); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (regwrite !== 1'b1 || wa !== 5'd9 || wd !== m_wd) begin
            errors++; $display("FAIL unstall_write got rw=%b wa=%0d wd=%h exp 1/9/%h", regwrite, wa, wd, m_wd);
        end
        tick();
    endtask

    task automatic test_bypass_reset();
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'hA5A5A5A5;
        tick();
        idle_inputs();
        chk_addr = 5'd6;
        @(negedge clk);
        checks++;
        if (chk_hit !== 1'b0) begin errors++; $display("FAIL bypass_miss got %b exp 0", chk_hit); end
        chk_addr = 5'd7;
        #1;
        checks++;
        if (chk_hit !== 1'b1 || chk_data !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL bypass_hit got hit=%b data=%h exp 1/a5a5a5a5", chk_hit, chk_data);
        end
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (regwrite !== 1'b0 || chk_hit !== 1'b0) begin
            errors++; $display("FAIL midreset_cancel got rw=%b hit=%b exp 0/0", regwrite, chk_hit);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic        p0, p1, e0, e1, eh;
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;
        p0 = 1'b0; p1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int c = 0; c < 400; c++) begin
            if (!p0 && $urandom_range(0, 1) == 1) begin
                p0 = 1'b1; a0 = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(0, 31)); d0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 1) == 1) begin
                p1 = 1'b1; a1 = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(0, 31)); d1 = $urandom;
            end
            req0_valid = p0; req0_addr = a0; req0_data = d0;
            req1_valid = p1; req1_addr = a1; req1_data = d1;
            stall = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 49) != 0);
            chk_addr = ($urandom_range(0, 1) == 1) ? m_wa : 5'($urandom_range(0, 31));
            @(negedge clk);
            e0 = exp_rdy(0);
            e1 = exp_rdy(1);
            eh = m_rw && (m_wa == chk_addr) && (chk_addr != 5'd0);
            checks++;
            if (req0_ready !== e0 || req1_ready !== e1) begin
                errors++; $display("FAIL rand_ready cyc %0d got %b%b exp %b%b", c, req1_ready, req0_ready, e1, e0);
            end
            checks++;
            if (regwrite !== m_rw || wa !== m_wa || wd !== m_wd) begin
                errors++; $display("FAIL rand_stage cyc %0d got %b/%0d/%h exp %b/%0d/%h", c, regwrite, wa, wd, m_rw, m_wa, m_wd);
            end
            checks++;
            if (wr_count !== m_cnt) begin errors++; $display("FAIL rand_count cyc %0d got %0d exp %0d", c, wr_count, m_cnt); end
            checks++;
            if (chk_hit !== eh || chk_data !== m_wd) begin
                errors++; $display("FAIL rand_bypass cyc %0d got %b/%h exp %b/%h", c, chk_hit, chk_data, eh, m_wd);
            end
            tick();
            if (e0 && p0) p0 = 1'b0;
            if (e1 && p1) p1 = 1'b0;
        end
        rst_n = 1'b1;
        idle_inputs();
        tick();
    endtask

    task automatic test_saturation();
        for (int c = 0; c < 260; c++) begin
            req0_valid = 1'b1; req0_addr = 5'($urandom_range(1, 31)); req0_data = $urandom;
            tick();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (wr_count !== 8'hFF || wr_count !== m_cnt) begin
            errors++; $display("FAIL saturate_count got %0d exp 255", wr_count);
        end
        checks++;
        if (regwrite !== 1'b1) begin errors++; $display("FAIL saturate_regwrite got %b exp 1", regwrite); end
        tick();
        @(negedge clk);
        checks++;
        if (wr_count !== 8'hFF) begin errors++; $display("FAIL saturate_hold got %0d exp 255", wr_count); end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        chk_addr = '0;
        m_prio = 1'b0; m_rw = 1'b0; m_wa = '0; m_wd = '0; m_cnt = '0;
        test_reset();
        test_single();
        test_contention();
        test_zero_discard();
        test_stall();
        test_bypass_reset();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
